// File: rtl/line_render_sched_pkg.sv
// Shared constants, state encoding and line helpers for the scanline render scheduler.
package line_render_sched_pkg;

   localparam int HTOTAL     = 1600;   // hcount period, clocks per line
   localparam int VTOTAL     = 525;    // lines per frame
   localparam int VACTIVE    = 480;    // visible lines
   localparam int TILE_HC    = 0;      // hcount at which a line's render is launched
   localparam int SWAP_HC    = 1590;   // hcount at which the bank select is evaluated
   localparam int CNT_W_DFLT = 16;     // default overrun counter width

   localparam int HC_W = 11;
   localparam int VC_W = 10;

   // Sized copies so comparisons against hcount/vcount stay width-matched.
   localparam logic [HC_W-1:0] TILE_HC_C = HC_W'(TILE_HC % HTOTAL);
   localparam logic [HC_W-1:0] SWAP_HC_C = HC_W'(SWAP_HC % HTOTAL);
   localparam logic [VC_W-1:0] VC_LAST_ACT = VC_W'(VACTIVE - 1);
   localparam logic [VC_W-1:0] VC_LAST     = VC_W'(VTOTAL - 1);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_T_GUARD = 3'd1,
      ST_T_WAIT  = 3'd2,
      ST_S_GUARD = 3'd3,
      ST_S_WAIT  = 3'd4,
      ST_DONE    = 3'd5,
      ST_DRAIN   = 3'd6
   } sched_state_t;

   // A line renders the line that follows it; the last frame line renders line 0.
   function automatic logic is_render_line(input logic [VC_W-1:0] vc);
      return (vc < VC_LAST_ACT) || (vc == VC_LAST);
   endfunction

   function automatic logic [VC_W-1:0] next_line(input logic [VC_W-1:0] vc);
      return (vc == VC_LAST) ? '0 : vc + VC_W'(1);
   endfunction

endpackage

// File: rtl/line_render_sched_sat_counter.sv
// Saturating event counter; a clear and an increment in the same cycle give 1.
module line_render_sched_sat_counter
   import line_render_sched_pkg::*;
#(
   parameter int CNT_W = CNT_W_DFLT
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inc_i,
   input  logic             clr_i,
   output logic [CNT_W-1:0] q_o
);

   logic [CNT_W-1:0] q_q;
   logic [CNT_W-1:0] q_d;
   logic [CNT_W-1:0] base;

   // Apply the clear first, then the increment, holding at all-ones.
   always_comb begin
      base = clr_i ? '0 : q_q;
      q_d  = base;
      if (inc_i && (base != '1)) begin
         q_d = base + CNT_W'(1);
      end
   end

   // Count register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q_q <= '0;
      end else begin
         q_q <= q_d;
      end
   end

   assign q_o = q_q;

endmodule

// File: rtl/line_render_sched.sv
// Per-scanline render scheduler: launches tile then sprite engine on each render line,
// flips the linebuffer bank at the swap point, and flags/counts late renders.
//
// Engine handshake: *_start is a one-cycle registered pulse; *_done is a level that is 1
// while the engine is idle/finished. An engine drops done one cycle after seeing start,
// so done is ignored for one guard cycle after each start.
module line_render_sched
   import line_render_sched_pkg::*;
#(
   parameter int CNT_W = CNT_W_DFLT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [HC_W-1:0]   hcount,
   input  logic [VC_W-1:0]   vcount,
   input  logic              enable,
   input  logic              clr_overrun,
   output logic              tile_start,
   input  logic              tile_done,
   output logic              sprite_start,
   input  logic              sprite_done,
   output logic              buf_sel,
   output logic [VC_W-1:0]   render_line,
   output logic              busy,
   output logic              overrun,
   output logic [CNT_W-1:0]  overrun_count,
   output logic [2:0]        state_o
);

   sched_state_t    state_q, state_d;
   logic            tile_start_q, tile_start_d;
   logic            sprite_start_q, sprite_start_d;
   logic            buf_sel_q, buf_sel_d;
   logic [VC_W-1:0] render_line_q, render_line_d;
   logic            busy_q, busy_d;
   logic            overrun_q, overrun_d;

   logic render_w;
   logic tile_pt;
   logic swap_pt;

   assign render_w = is_render_line(vcount);
   assign tile_pt  = render_w && (hcount == TILE_HC_C);
   assign swap_pt  = render_w && (hcount == SWAP_HC_C);

   // Next state and next registered outputs; the swap point overrides normal progress.
   always_comb begin
      state_d        = state_q;
      tile_start_d   = 1'b0;
      sprite_start_d = 1'b0;
      buf_sel_d      = buf_sel_q;
      render_line_d  = render_line_q;
      overrun_d      = 1'b0;
      if (swap_pt) begin
         if (state_q == ST_DONE) begin
            buf_sel_d = ~buf_sel_q;
            state_d   = ST_IDLE;
         end else if (state_q == ST_IDLE) begin
            // Idle while enabled means this line's launch was skipped; parked is silent.
            overrun_d = enable;
         end else begin
            overrun_d = 1'b1;
            state_d   = ST_DRAIN;
         end
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (tile_pt && enable) begin
                  tile_start_d  = 1'b1;
                  render_line_d = next_line(vcount);
                  state_d       = ST_T_GUARD;
               end
            end
            ST_T_GUARD: state_d = ST_T_WAIT;
            ST_T_WAIT: begin
               if (tile_done) begin
                  sprite_start_d = 1'b1;
                  state_d        = ST_S_GUARD;
               end
            end
            ST_S_GUARD: state_d = ST_S_WAIT;
            ST_S_WAIT: begin
               if (sprite_done) begin
                  state_d = ST_DONE;
               end
            end
            ST_DONE: state_d = ST_DONE;
            ST_DRAIN: begin
               if (tile_done && sprite_done) begin
                  state_d = ST_IDLE;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
      busy_d = (state_d != ST_IDLE) && (state_d != ST_DONE);
   end

   // State and output registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q        <= ST_IDLE;
         tile_start_q   <= 1'b0;
         sprite_start_q <= 1'b0;
         buf_sel_q      <= 1'b0;
         render_line_q  <= '0;
         busy_q         <= 1'b0;
         overrun_q      <= 1'b0;
      end else begin
         state_q        <= state_d;
         tile_start_q   <= tile_start_d;
         sprite_start_q <= sprite_start_d;
         buf_sel_q      <= buf_sel_d;
         render_line_q  <= render_line_d;
         busy_q         <= busy_d;
         overrun_q      <= overrun_d;
      end
   end

   line_render_sched_sat_counter #(
      .CNT_W (CNT_W)
   ) u_overrun_cnt (
      .clk   (clk),
      .reset (reset),
      .inc_i (overrun_d),
      .clr_i (clr_overrun),
      .q_o   (overrun_count)
   );

   assign tile_start   = tile_start_q;
   assign sprite_start = sprite_start_q;
   assign buf_sel      = buf_sel_q;
   assign render_line  = render_line_q;
   assign busy         = busy_q;
   assign overrun      = overrun_q;
   assign state_o      = state_q;

endmodule

// File: tb/tb_line_render_sched.sv
// Bench for line_render_sched: behavioural engines plus an event-level reference model.
module tb_line_render_sched;

   // Narrow counter so that saturation is reachable in a short run.
   localparam int CW  = 12;
   localparam int VW  = 15 + CW;
   localparam int HT  = 1600;
   localparam int VT  = 525;
   localparam int VA  = 480;
   localparam int THC = 0;
   localparam int SHC = 1590;

   logic          clk = 1'b0;
   logic          reset;
   logic [10:0]   hcount;
   logic [9:0]    vcount;
   logic          enable;
   logic          clr_overrun;
   logic          tile_start;
   logic          tile_done;
   logic          sprite_start;
   logic          sprite_done;
   logic          buf_sel;
   logic [9:0]    render_line;
   logic          busy;
   logic          overrun;
   logic [CW-1:0] overrun_count;
   logic [2:0]    state_o;

   int checks   = 0;
   int failures = 0;

   // stimulus controls
   int          cyc         = 0;
   int          dt          = 20;
   int          ds          = 300;
   int          en_drop_hc  = -1;
   int          rst_hc      = -1;
   int unsigned clr_pm      = 0;
   bit          force_clr   = 1'b0;

   // engine models: done drops the cycle after start is seen, stays low for N cycles
   bit t_pend = 1'b0;
   bit s_pend = 1'b0;
   int t_low  = 0;
   int s_low  = 0;

   // reference model
   bit       m_active;
   int       m_t_rise;
   int       m_done_edge;
   int       m_free_at;
   bit       m_buf;
   int       m_cnt;
   bit [9:0] m_rl;
   bit       e_ts, e_ss, e_ov, e_busy;

   logic [VW-1:0] obs, expv;
   logic [CW-1:0] all_ones;

   line_render_sched #(.CNT_W(CW)) dut (
      .clk           (clk),
      .reset         (reset),
      .hcount        (hcount),
      .vcount        (vcount),
      .enable        (enable),
      .clr_overrun   (clr_overrun),
      .tile_start    (tile_start),
      .tile_done     (tile_done),
      .sprite_start  (sprite_start),
      .sprite_done   (sprite_done),
      .buf_sel       (buf_sel),
      .render_line   (render_line),
      .busy          (busy),
      .overrun       (overrun),
      .overrun_count (overrun_count),
      .state_o       (state_o)
   );

   always #10 clk = ~clk;

   function automatic bit is_rl(input int vc);
      return (vc < VA - 1) || (vc == VT - 1);
   endfunction

   function automatic void model_reset();
      m_active    = 1'b0;
      m_t_rise    = 0;
      m_done_edge = 0;
      m_free_at   = -1;
      m_buf       = 1'b0;
      m_cnt       = 0;
      m_rl        = '0;
      e_ts = 1'b0; e_ss = 1'b0; e_ov = 1'b0; e_busy = 1'b0;
   endfunction

   // What the scheduler must show after the clock edge of cycle cyc.
   // m_free_at: edge at which the late engines are both done again (scheduler free after it).
   function automatic void model_edge(input int hc, input int vc, input bit en, input bit clr);
      int c;
      bit rl;
      c  = cyc;
      rl = is_rl(vc);
      e_ts = 1'b0; e_ss = 1'b0; e_ov = 1'b0;
      if (rl && hc == SHC) begin
         if (m_active) begin
            if (c > m_done_edge) begin
               m_buf = ~m_buf;
            end else begin
               e_ov = 1'b1;
               m_free_at = (c > m_t_rise) ? m_done_edge : m_t_rise;
               if (m_free_at <= c) m_free_at = c + 1;
            end
            m_active = 1'b0;
         end else if (c <= m_free_at || en) begin
            e_ov = 1'b1;
            if (m_free_at == c) m_free_at = c + 1;
         end
      end else begin
         if (m_active && c == m_t_rise) e_ss = 1'b1;
         if (!m_active && rl && hc == THC && en && c > m_free_at) begin
            e_ts        = 1'b1;
            m_active    = 1'b1;
            m_t_rise    = c + dt + 2;
            m_done_edge = c + dt + ds + 4;
            m_rl        = (vc == VT - 1) ? 10'd0 : 10'(vc + 1);
         end
      end
      if (clr) m_cnt = 0;
      if (e_ov && m_cnt < (1 << CW) - 1) m_cnt++;
      e_busy = (m_active && c < m_done_edge) || (c < m_free_at);
   endfunction

   task automatic finish_run();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   endtask

   // One clock cycle: drive inputs, let the edge happen, compare all outputs, react as engines.
   task automatic step(input int hc, input int vc);
      hcount = 11'(hc);
      vcount = 10'(vc);
      if (hc == en_drop_hc) enable = 1'b0;
      clr_overrun = force_clr || ($urandom_range(0, 999) < clr_pm);
      if (t_pend) begin tile_done = 1'b1; t_pend = 1'b0; end
      else if (t_low > 0) begin tile_done = 1'b0; t_low--; end
      else tile_done = 1'b1;
      if (s_pend) begin sprite_done = 1'b1; s_pend = 1'b0; end
      else if (s_low > 0) begin sprite_done = 1'b0; s_low--; end
      else sprite_done = 1'b1;
      @(posedge clk);
      model_edge(hc, vc, enable, clr_overrun);
      #1;
      checks++;
      obs  = {tile_start, sprite_start, overrun, buf_sel, busy, render_line, overrun_count};
      expv = {e_ts, e_ss, e_ov, m_buf, e_busy, m_rl, CW'(m_cnt)};
      assert (obs === expv) else begin
         failures++;
         $error("FAIL cycle_outputs cyc=%0d hc=%0d vc=%0d got=%h expected=%h", cyc, hc, vc, obs, expv);
      end
      if (tile_start === 1'b1) begin t_pend = 1'b1; t_low = dt; end
      if (sprite_start === 1'b1) begin s_pend = 1'b1; s_low = ds; end
      if (hc == rst_hc) begin
         #2 reset = 1'b1;
         #1;
         checks++;
         obs = {tile_start, sprite_start, overrun, buf_sel, busy, render_line, overrun_count};
         assert (obs === '0) else begin
            failures++;
            $error("FAIL async_reset got=%h expected=0", obs);
         end
         model_reset();
         #2 reset = 1'b0;
      end
      cyc++;
      if (failures > 40) finish_run();
   endtask

   task automatic run_line(input int vc);
      for (int hc = 0; hc < HT; hc++) step(hc, vc);
   endtask

   initial begin
      reset = 1'b1; enable = 1'b1; clr_overrun = 1'b0;
      hcount = 11'd5; vcount = 10'd0; tile_done = 1'b1; sprite_done = 1'b1;
      all_ones = '1;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      checks++;
      obs = {tile_start, sprite_start, overrun, buf_sel, busy, render_line, overrun_count};
      assert (obs === '0) else begin
         failures++;
         $error("FAIL reset_state got=%h expected=0", obs);
      end
      reset = 1'b0;

      // normal renders
      dt = 20; ds = 300;
      run_line(4);
      run_line(5);
      // finish one cycle before the swap edge versus exactly at it
      ds = 1565; run_line(6);
      ds = 1566; run_line(7);
      ds = 300;  run_line(8);
      // sprite late into next line: overrun, skipped line, second overrun, recovery
      ds = 1676; run_line(9);
      ds = 300;  run_line(10);
      run_line(11);
      // frame wrap and non-render lines
      run_line(478);
      run_line(479);
      run_line(480);
      run_line(523);
      run_line(524);
      run_line(0);
      // enable dropped mid-render, then parked line, then re-enabled
      en_drop_hc = 100; run_line(20);
      en_drop_hc = -1;  run_line(21);
      enable = 1'b1;    run_line(22);
      // async reset while sprite engine is running
      dt = 20; ds = 600;
      rst_hc = 500; run_line(30);
      rst_hc = -1;  run_line(31);
      // randomized lines
      clr_pm = 2;
      for (int i = 0; i < 6; i++) begin
         dt = $urandom_range(0, 120);
         ds = $urandom_range(0, 1700);
         enable = ($urandom_range(0, 7) != 0);
         run_line($urandom_range(0, VT - 1));
      end
      clr_pm = 0;
      // let any drain finish while parked on a non-render line
      enable = 1'b0;
      run_line(479);
      run_line(479);
      enable = 1'b1;
      // saturation: idle and enabled at the swap point every cycle
      for (int i = 0; i < (1 << CW) + 3; i++) step(SHC, 10);
      checks++;
      assert (overrun_count === all_ones) else begin
         failures++;
         $error("FAIL saturate got=%h expected=%h", overrun_count, all_ones);
      end
      force_clr = 1'b1;
      step(SHC, 10);
      checks++;
      assert (overrun_count === CW'(1)) else begin
         failures++;
         $error("FAIL clear_with_overrun got=%h expected=1", overrun_count);
      end
      step(100, 10);
      checks++;
      assert (overrun_count === CW'(0)) else begin
         failures++;
         $error("FAIL clear_only got=%h expected=0", overrun_count);
      end
      force_clr = 1'b0;
      finish_run();
   end

endmodule
